// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// Grants at most one request per cycle (round-robin by default), muxes the
// granted operands onto the ALU and captures the result into a per-port
// response register held until the requester drains it.
// Optional build macro: ALU_ARB_FIXED_PRI_EN selects fixed priority (port 0
// wins contention) instead of round-robin.

module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic [3:0]       r0_f,
    output logic             r0_rsp_valid,
    input  logic             r0_rsp_ready,
    output logic [WIDTH-1:0] r0_rsp_y,
    output logic             r0_rsp_zero,

    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    input  logic [3:0]       r1_f,
    output logic             r1_rsp_valid,
    input  logic             r1_rsp_ready,
    output logic [WIDTH-1:0] r1_rsp_y,
    output logic             r1_rsp_zero,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_f,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero
);

    localparam int unsigned FW = 4;

    logic             elig0;
    logic             elig1;
    logic             gnt0;
    logic             gnt1;

    logic             rsp0_valid_q, rsp0_valid_d;
    logic [WIDTH-1:0] rsp0_y_q,     rsp0_y_d;
    logic             rsp0_zero_q,  rsp0_zero_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic [WIDTH-1:0] rsp1_y_q,     rsp1_y_d;
    logic             rsp1_zero_q,  rsp1_zero_d;

`ifndef ALU_ARB_FIXED_PRI_EN
    // Index of the port granted most recently; the other port wins contention.
    logic             last_q, last_d;
`endif

    // A port holding an undrained response cannot accept a new one.
    assign elig0 = r0_valid && (!rsp0_valid_q || r0_rsp_ready);
    assign elig1 = r1_valid && (!rsp1_valid_q || r1_rsp_ready);

    // Grant selection; suppressed while reset is asserted so no handshake is lost.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (elig0 && elig1) begin
`ifdef ALU_ARB_FIXED_PRI_EN
                gnt0 = 1'b1;
`else
                gnt0 = last_q;
                gnt1 = !last_q;
`endif
            end else begin
                gnt0 = elig0;
                gnt1 = elig1;
            end
        end
    end

    assign r0_ready = gnt0;
    assign r1_ready = gnt1;

    // ALU operand mux; drives zeros when nothing is granted.
    always_comb begin
        alu_a = '0;
        alu_b = '0;
        alu_f = FW'(0);
        if (gnt0) begin
            alu_a = r0_a;
            alu_b = r0_b;
            alu_f = r0_f;
        end else if (gnt1) begin
            alu_a = r1_a;
            alu_b = r1_b;
            alu_f = r1_f;
        end
    end

    // Response capture/drain and pointer next-state.
    always_comb begin
        rsp0_valid_d = rsp0_valid_q;
        rsp0_y_d     = rsp0_y_q;
        rsp0_zero_d  = rsp0_zero_q;
        rsp1_valid_d = rsp1_valid_q;
        rsp1_y_d     = rsp1_y_q;
        rsp1_zero_d  = rsp1_zero_q;
`ifndef ALU_ARB_FIXED_PRI_EN
        last_d       = last_q;
`endif
        if (gnt0) begin
            rsp0_valid_d = 1'b1;
            rsp0_y_d     = alu_y;
            rsp0_zero_d  = alu_zero;
        end else if (rsp0_valid_q && r0_rsp_ready) begin
            rsp0_valid_d = 1'b0;
        end
        if (gnt1) begin
            rsp1_valid_d = 1'b1;
            rsp1_y_d     = alu_y;
            rsp1_zero_d  = alu_zero;
        end else if (rsp1_valid_q && r1_rsp_ready) begin
            rsp1_valid_d = 1'b0;
        end
`ifndef ALU_ARB_FIXED_PRI_EN
        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end
`endif
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp0_valid_q <= 1'b0;
            rsp0_y_q     <= '0;
            rsp0_zero_q  <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp1_y_q     <= '0;
            rsp1_zero_q  <= 1'b0;
`ifndef ALU_ARB_FIXED_PRI_EN
            last_q       <= 1'b1;
`endif
        end else begin
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_y_q     <= rsp0_y_d;
            rsp0_zero_q  <= rsp0_zero_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_y_q     <= rsp1_y_d;
            rsp1_zero_q  <= rsp1_zero_d;
`ifndef ALU_ARB_FIXED_PRI_EN
            last_q       <= last_d;
`endif
        end
    end

    assign r0_rsp_valid = rsp0_valid_q;
    assign r0_rsp_y     = rsp0_y_q;
    assign r0_rsp_zero  = rsp0_zero_q;
    assign r1_rsp_valid = rsp1_valid_q;
    assign r1_rsp_y     = rsp1_y_q;
    assign r1_rsp_zero  = rsp1_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: supplies a behavioural ALU and compares the DUT
// against a transaction-level model of grants and held responses.

module tb_alu_arbiter;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       vld;
    logic [1:0]       rrdy;
    logic [WIDTH-1:0] a [2];
    logic [WIDTH-1:0] b [2];
    logic [3:0]       f [2];

    logic             rdy0, rdy1, rv0, rv1, rz0, rz1;
    logic [WIDTH-1:0] ry0, ry1;
    logic [WIDTH-1:0] alu_a, alu_b, alu_y;
    logic [3:0]       alu_f;
    logic             alu_zero;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: what each port should be holding, and who was granted last.
    bit               m_vld [2];
    logic [WIDTH-1:0] m_y   [2];
    bit               m_z   [2];
    int               m_last;
    int               g_last;

    always #5 clk = ~clk;

    // Behavioural ALU used both as the DUT's ALU and by the model.
    function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic [3:0] fc);
        case (fc)
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b0010: return x + y;
            4'b0011: return x ^ y;
            4'b1010: return x - y;
            default: return '0;
        endcase
    endfunction

    assign alu_y    = alu_fn(alu_a, alu_b, alu_f);
    assign alu_zero = (alu_y == '0);

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .r0_valid     (vld[0]),
        .r0_ready     (rdy0),
        .r0_a         (a[0]),
        .r0_b         (b[0]),
        .r0_f         (f[0]),
        .r0_rsp_valid (rv0),
        .r0_rsp_ready (rrdy[0]),
        .r0_rsp_y     (ry0),
        .r0_rsp_zero  (rz0),
        .r1_valid     (vld[1]),
        .r1_ready     (rdy1),
        .r1_a         (a[1]),
        .r1_b         (b[1]),
        .r1_f         (f[1]),
        .r1_rsp_valid (rv1),
        .r1_rsp_ready (rrdy[1]),
        .r1_rsp_y     (ry1),
        .r1_rsp_zero  (rz1),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_f        (alu_f),
        .alu_y        (alu_y),
        .alu_zero     (alu_zero)
    );

    // Which port should win this cycle (-1 for none), from the arbitration rules.
    function automatic int exp_grant();
        bit e [2];
        for (int i = 0; i < 2; i++) e[i] = vld[i] && (!m_vld[i] || rrdy[i]);
        if (e[0] && e[1]) begin
`ifdef ALU_ARB_FIXED_PRI_EN
            return 0;
`else
            return 1 - m_last;
`endif
        end
        if (e[0]) return 0;
        if (e[1]) return 1;
        return -1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_vld[i] = 1'b0;
            m_y[i]   = '0;
            m_z[i]   = 1'b0;
        end
        m_last = 1;
        g_last = -1;
    endfunction

    // One clock cycle: entered at posedge+1 with inputs set, leaves at next posedge+1.
    task automatic cycle_check(input string tag);
        int               g;
        logic [WIDTH-1:0] ea, eb;
        logic [3:0]       ef;
        #4;
        g  = exp_grant();
        ea = '0;
        eb = '0;
        ef = 4'b0000;
        if (g >= 0) begin
            ea = a[g];
            eb = b[g];
            ef = f[g];
        end
        n_vec++;
        if ({rdy1, rdy0} !== {g == 1, g == 0}) begin
            n_err++;
            $display("FAIL %s ready: got r1/r0=%b%b want %b%b", tag, rdy1, rdy0, g == 1, g == 0);
        end
        n_vec++;
        if (alu_a !== ea || alu_b !== eb || alu_f !== ef) begin
            n_err++;
            $display("FAIL %s alu_bus: got %h/%h/%h want %h/%h/%h", tag, alu_a, alu_b, alu_f, ea, eb, ef);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (g == i) begin
                m_vld[i] = 1'b1;
                m_y[i]   = alu_fn(a[i], b[i], f[i]);
                m_z[i]   = (m_y[i] == '0);
            end else if (m_vld[i] && rrdy[i]) begin
                m_vld[i] = 1'b0;
            end
        end
        if (g >= 0) m_last = g;
        g_last = g;
        #1;
        n_vec++;
        if (rv0 !== m_vld[0] || ry0 !== m_y[0] || rz0 !== m_z[0]) begin
            n_err++;
            $display("FAIL %s rsp0: got v=%b y=%h z=%b want v=%b y=%h z=%b", tag, rv0, ry0, rz0, m_vld[0], m_y[0], m_z[0]);
        end
        n_vec++;
        if (rv1 !== m_vld[1] || ry1 !== m_y[1] || rz1 !== m_z[1]) begin
            n_err++;
            $display("FAIL %s rsp1: got v=%b y=%h z=%b want v=%b y=%h z=%b", tag, rv1, ry1, rz1, m_vld[1], m_y[1], m_z[1]);
        end
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        n_vec++;
        if (rv0 !== 1'b0 || rv1 !== 1'b0 || ry0 !== '0 || ry1 !== '0 || rz0 !== 1'b0 || rz1 !== 1'b0) begin
            n_err++;
            $display("FAIL %s reset_state: got v=%b%b y=%h/%h z=%b%b want all zero", tag, rv1, rv0, ry1, ry0, rz1, rz0);
        end
    endtask

    task automatic test_reset();
        do_reset("reset");
        vld  = 2'b00;
        rrdy = 2'b00;
        cycle_check("reset_idle");
    endtask

    task automatic test_single();
        vld  = 2'b01;
        rrdy = 2'b11;
        a[0] = 32'd5;
        b[0] = 32'd7;
        f[0] = 4'b0010;
        cycle_check("single");
        n_vec++;
        if (g_last !== 0 || rv0 !== 1'b1 || ry0 !== 32'd12 || rz0 !== 1'b0) begin
            n_err++;
            $display("FAIL single_result: got g=%0d v=%b y=%0d z=%b want g=0 v=1 y=12 z=0", g_last, rv0, ry0, rz0);
        end
        vld = 2'b00;
        cycle_check("single_drain");
    endtask

    task automatic test_contention();
        int prev;
        int want;
        vld  = 2'b11;
        rrdy = 2'b11;
        prev = -1;
        for (int i = 0; i < 10; i++) begin
            cycle_check("contention");
            if (i > 0) begin
`ifdef ALU_ARB_FIXED_PRI_EN
                want = 0;
`else
                want = (prev == 0) ? 1 : 0;
`endif
                n_vec++;
                if (g_last !== want) begin
                    n_err++;
                    $display("FAIL contention_order: cycle %0d got grant %0d want %0d", i, g_last, want);
                end
            end
            prev = g_last;
            if (g_last >= 0) begin
                a[g_last] = $urandom;
                b[g_last] = $urandom;
                f[g_last] = 4'($urandom_range(0, 15));
            end
        end
        vld = 2'b00;
        cycle_check("contention_drain");
    endtask

    task automatic test_backpressure();
        vld  = 2'b10;
        rrdy = 2'b01;
        a[1] = 32'd1;
        b[1] = 32'd2;
        f[1] = 4'b0010;
        cycle_check("bp_first");
        n_vec++;
        if (rv1 !== 1'b1 || ry1 !== 32'd3) begin
            n_err++;
            $display("FAIL bp_held: got v=%b y=%0d want v=1 y=3", rv1, ry1);
        end
        vld  = 2'b11;
        a[0] = 32'h10;
        b[0] = 32'h01;
        f[0] = 4'b0001;
        a[1] = 32'd4;
        b[1] = 32'd4;
        cycle_check("bp_blocked");
        n_vec++;
        if (g_last !== 0 || ry1 !== 32'd3) begin
            n_err++;
            $display("FAIL bp_blocked_grant: got g=%0d y1=%0d want g=0 y1=3", g_last, ry1);
        end
        vld  = 2'b10;
        rrdy = 2'b11;
        cycle_check("bp_release");
        n_vec++;
        if (g_last !== 1 || rv1 !== 1'b1 || ry1 !== 32'd8) begin
            n_err++;
            $display("FAIL bp_release_grant: got g=%0d v=%b y=%0d want g=1 v=1 y=8", g_last, rv1, ry1);
        end
    endtask

    task automatic test_zero();
        vld  = 2'b10;
        rrdy = 2'b11;
        a[1] = 32'd9;
        b[1] = 32'd9;
        f[1] = 4'b1010;
        cycle_check("zero");
        n_vec++;
        if (rv1 !== 1'b1 || ry1 !== '0 || rz1 !== 1'b1) begin
            n_err++;
            $display("FAIL zero_flag: got v=%b y=%h z=%b want v=1 y=0 z=1", rv1, ry1, rz1);
        end
    endtask

    task automatic test_idle();
        vld  = 2'b00;
        rrdy = 2'b00;
        for (int i = 0; i < 3; i++) cycle_check("idle");
        n_vec++;
        if (rv1 !== 1'b1 || rz1 !== 1'b1) begin
            n_err++;
            $display("FAIL idle_hold: got v1=%b z1=%b want 1 1", rv1, rz1);
        end
        vld  = 2'b11;
        rrdy = 2'b11;
        cycle_check("idle_then_contend");
        n_vec++;
        if (g_last !== 0) begin
            n_err++;
            $display("FAIL idle_pointer: got grant %0d want 0", g_last);
        end
        vld = 2'b00;
        cycle_check("idle_drain");
    endtask

    task automatic test_reset_mid();
        vld  = 2'b01;
        rrdy = 2'b00;
        a[0] = 32'd3;
        b[0] = 32'd4;
        f[0] = 4'b0010;
        cycle_check("mid_fill0");
        vld  = 2'b10;
        a[1] = 32'd6;
        b[1] = 32'd1;
        f[1] = 4'b1010;
        cycle_check("mid_fill1");
        n_vec++;
        if (rv0 !== 1'b1 || rv1 !== 1'b1) begin
            n_err++;
            $display("FAIL mid_both_held: got v=%b%b want 11", rv1, rv0);
        end
        vld = 2'b11;
        do_reset("mid_reset");
        rrdy = 2'b11;
        cycle_check("mid_after");
        n_vec++;
        if (g_last !== 0) begin
            n_err++;
            $display("FAIL mid_first_grant: got %0d want 0", g_last);
        end
        vld = 2'b00;
        cycle_check("mid_drain");
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!(vld[i] && g_last != i)) begin
                    vld[i] = ($urandom_range(0, 3) != 0);
                    a[i]   = ($urandom_range(0, 7) == 0) ? a[1-i] : $urandom;
                    b[i]   = ($urandom_range(0, 3) == 0) ? a[i] : $urandom;
                    f[i]   = 4'($urandom_range(0, 15));
                end
                rrdy[i] = ($urandom_range(0, 2) != 0);
            end
            cycle_check("random");
        end
    endtask

    initial begin
        reset = 1'b1;
        vld   = 2'b00;
        rrdy  = 2'b00;
        for (int i = 0; i < 2; i++) begin
            a[i] = '0;
            b[i] = '0;
            f[i] = 4'b0000;
        end
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_zero();
        test_idle();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter that shares the single combinational ALU (32-bit operands, 4-bit function code) between two requesters, e.g. the main datapath and a secondary execution unit. It grants at most one request per cycle (round-robin by default), drives the granted operands and function code into the ALU, and captures the ALU result into a per-port response register. Each response register is held until its requester drains it.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must match the ALU.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- r0_valid  input  1  port 0 request valid.
- r0_ready  output  1  port 0 request accepted this cycle (grant).
- r0_a, r0_b  input  WIDTH  port 0 operands.
- r0_f  input  4  port 0 ALU function code, passed through unchanged.
- r0_rsp_valid  output  1  port 0 response held.
- r0_rsp_ready  input  1  port 0 consumes response.
- r0_rsp_y  output  WIDTH  port 0 result.
- r0_rsp_zero  output  1  port 0 zero flag.
- r1_* (same nine ports as r0_*)  port 1.
- alu_a, alu_b  output  WIDTH  ALU operands.
- alu_f  output  4  ALU function code.
- alu_y  input  WIDTH  ALU result.
- alu_zero  input  1  ALU zero flag.

## Operation
- Eligibility: port i is eligible when ri_valid && (!ri_rsp_valid || ri_rsp_ready). A port with an undrained response is never granted.
- Grant: combinational.
  - Exactly one eligible port: that port is granted.
  - Both eligible: the port not granted last wins, per the 1-bit pointer `last`.
  - ri_ready = grant_i. A handshake completes when ri_valid && ri_ready.
- ALU drive: combinational mux of the granted port's a/b/f. With no grant: alu_a = alu_b = 0 and alu_f = 4'b0000.
- Capture: on the clock edge of a grant to port i, ri_rsp_y <= alu_y, ri_rsp_zero <= alu_zero, ri_rsp_valid <= 1.
- Drain: ri_rsp_valid && ri_rsp_ready with no new grant to i clears ri_rsp_valid. ri_rsp_y and ri_rsp_zero retain their stale values.
- Simultaneous drain and grant on the same port: the new result replaces the old one and rsp_valid stays 1.
- Pointer: `last` <= granted port index on every grant. It is unchanged in idle cycles.
- The function code is never interpreted. Unsupported codes yield whatever the ALU returns (0).
- Request inputs must be stable while ri_valid is high and ri_ready is low.

## Timing
- Reset values:
  - r0_rsp_valid = r1_rsp_valid = 0.
  - r0_rsp_y = r1_rsp_y = 0; r0_rsp_zero = r1_rsp_zero = 0.
  - `last` = 1, so port 0 wins the first contention.
- Outputs after reset: r0_ready = r1_ready = 0 while no request is valid.
- Reset mid-operation: any held response is discarded and grants resume on the first cycle after reset deasserts.
- Latency: grant in cycle N gives rsp_valid and rsp_y in cycle N+1.
- Throughput:
  - One ALU operation per cycle in aggregate.
  - With both ports continuously valid and rsp_ready high, grants strictly alternate.
  - A single active port with rsp_ready high is granted every cycle.
- Backpressure: with rsp_ready low, a port gets at most one outstanding result; its next grant waits until the cycle rsp_ready is high.
- No combinational path from alu_y/alu_zero to any r*_ready output.

## Configuration
- ALU_ARB_FIXED_PRI_EN:
  - Defined: fixed priority; port 0 always wins when both are eligible. `last` is not implemented.
  - Undefined: round-robin as described above.
- The macro has no other effect on behaviour, reset values or latency.

## Test plan
- Single request: after reset, r0 requests a=5, b=7, f=4'b0010 → r0_ready=1 that cycle, alu_a=5, alu_b=7, alu_f=4'b0010. Next cycle r0_rsp_valid=1, r0_rsp_y=12, r0_rsp_zero=0.
- Contention: both ports valid every cycle with rsp_ready=1.
  - Round-robin: grants go r0, r1, r0, r1 …
  - ALU_ARB_FIXED_PRI_EN: r0 is granted every cycle.
- Backpressure: r1 holds rsp_ready=0 with result 3 held; r1 requests again → r1_ready=0 and r0 can still be granted. Raising r1_rsp_ready → r1 granted the same cycle and rsp_y replaced on the next edge.
- Zero flag: r1 requests a=9, b=9, f=4'b1010 (subtract) → next cycle r1_rsp_y=0, r1_rsp_zero=1.
- Idle: no valid requests → alu_a=0, alu_b=0, alu_f=0; rsp_valid unchanged; `last` unchanged.
- Reset mid-operation: both responses valid, assert reset for one cycle → both rsp_valid=0 and rsp_y=0. The next contention grants r0 first.
